// File: rtl/ahb_sram_if_if.sv
// AHB-Lite bus bundle between an AHB master/interconnect and the ahb_sram_if slave.
// Handshake: an address phase is taken on a cycle where HSEL & HREADY & HTRANS[1] are high
// and the slave's HREADYOUT is high. A data phase completes on the first cycle with HREADYOUT=1.
// HRESP and HRDATA are meaningful in that completing cycle, and HWDATA must be held until then.
interface ahb_sram_if_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_sram_if.sv
// AHB-Lite slave bridging to a single-port synchronous SRAM (registered address, data next cycle).
// Define AHB_SRAM_IF_ERR_EN to answer illegal size/alignment with a two-cycle ERROR response.
module ahb_sram_if #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTES         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  ahb_sram_if_if.slave             ahb,
  output logic [ADDRESS_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0]    sram_data,
  output logic [BYTES-1:0]         sram_b_en,
  output logic                     sram_wren,
  input  logic [DATA_WIDTH-1:0]    sram_q,
  output logic [2:0]               dbg_state
);

  // State names the kind of data phase currently on the bus.
`ifdef AHB_SRAM_IF_ERR_EN
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD       = 3'd2,
    RD_STALL = 3'd3,
    ERR1     = 3'd4,
    ERR2     = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD       = 3'd2,
    RD_STALL = 3'd3
  } state_t;
`endif

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [BYTES-1:0]         lanes_q, lanes_d;
  logic [ADDRESS_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0]    sram_data_q, sram_data_d;

  logic [ADDRESS_WIDTH-1:0] haddr_word;
  logic [BYTES-1:0]         lane_dec;
  logic                     bad_xfer;
  logic                     accept;
  logic                     hreadyout_c;
  logic                     hresp_c;
  logic [DATA_WIDTH-1:0]    hrdata_c;
  logic                     sram_wren_c;
  logic [BYTES-1:0]         sram_b_en_c;
  logic                     unused_bits;

  assign haddr_word  = ahb.HADDR[ADDRESS_WIDTH+1:2];
  assign unused_bits = ^{ahb.HADDR[31:ADDRESS_WIDTH+2], ahb.HTRANS[0]};

  always_comb begin
    lane_dec = '1;
    case (ahb.HSIZE)
      3'd0:    lane_dec = BYTES'(1) << ahb.HADDR[1:0];
      3'd1:    lane_dec = BYTES'(3) << {ahb.HADDR[1], 1'b0};
      default: lane_dec = '1;
    endcase
  end

  assign bad_xfer = (ahb.HSIZE > 3'd2)
                  | ((ahb.HSIZE == 3'd1) & ahb.HADDR[0])
                  | ((ahb.HSIZE == 3'd2) & (|ahb.HADDR[1:0]));

  always_comb begin
    hreadyout_c = 1'b1;
    hresp_c     = 1'b0;
    hrdata_c    = '0;
    sram_wren_c = 1'b0;
    sram_b_en_c = '0;
    sram_addr_d = sram_addr_q;
    sram_data_d = sram_data_q;
    state_d     = IDLE;
    addr_d      = addr_q;
    lanes_d     = lanes_q;
    accept      = 1'b0;

    case (state_q)
      WR: begin
        sram_wren_c = 1'b1;
        sram_b_en_c = lanes_q;
        sram_addr_d = addr_q;
        sram_data_d = ahb.HWDATA;
      end
      RD:       hrdata_c = sram_q;
      RD_STALL: begin
        hreadyout_c = 1'b0;
        sram_addr_d = addr_q;
      end
`ifdef AHB_SRAM_IF_ERR_EN
      ERR1: begin
        hresp_c     = 1'b1;
        hreadyout_c = 1'b0;
      end
      ERR2:     hresp_c = 1'b1;
`endif
      default: ;
    endcase

    // A stalled data phase blocks any new address phase, even if HREADY is forced high.
    accept = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1] & hreadyout_c;

    if (state_q == RD_STALL) begin
      state_d = RD;
`ifdef AHB_SRAM_IF_ERR_EN
    end else if (state_q == ERR1) begin
      state_d = ERR2;
`endif
    end else if (accept) begin
      if (bad_xfer) begin
`ifdef AHB_SRAM_IF_ERR_EN
        state_d = ERR1;
`else
        state_d = IDLE;
`endif
      end else if (ahb.HWRITE) begin
        state_d = WR;
        addr_d  = haddr_word;
        lanes_d = lane_dec;
      end else if (state_q == WR) begin
        // SRAM port is busy with the write this cycle; replay the read address next cycle.
        state_d = RD_STALL;
        addr_d  = haddr_word;
      end else begin
        state_d     = RD;
        sram_addr_d = haddr_word;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      lanes_q     <= '0;
      sram_addr_q <= '0;
      sram_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      lanes_q     <= lanes_d;
      sram_addr_q <= sram_addr_d;
      sram_data_q <= sram_data_d;
    end
  end

  assign ahb.HREADYOUT = hreadyout_c;
  assign ahb.HRESP     = hresp_c;
  assign ahb.HRDATA    = hrdata_c;
  assign sram_addr     = sram_addr_d;
  assign sram_data     = sram_data_d;
  assign sram_b_en     = sram_b_en_c;
  assign sram_wren     = sram_wren_c;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ahb_sram_if.sv
// Bench for ahb_sram_if: pipelined AHB driver, SRAM model, reference memory and expected-result queue.
module tb_ahb_sram_if;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int BY    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int XW    = DW + 4;
`ifdef AHB_SRAM_IF_ERR_EN
  localparam int   ERR_WAIT = 1;
  localparam logic ERR_RESP = 1'b1;
`else
  localparam int   ERR_WAIT = 0;
  localparam logic ERR_RESP = 1'b0;
`endif

  typedef struct {
    logic          write;
    logic [2:0]    size;
    logic [31:0]   addr;
    logic [DW-1:0] wdata;
    int            exp_waits;
    logic          exp_resp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_init = 1'b1;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data;
  logic [BY-1:0] sram_b_en;
  logic          sram_wren;
  logic [DW-1:0] sram_q;
  logic [2:0]    dbg_state;

  ahb_sram_if_if #(.DATA_WIDTH(DW)) bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_sram_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BYTES(BY)) dut (
    .clk       (clk),
    .rst       (rst),
    .ahb       (bus),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_b_en (sram_b_en),
    .sram_wren (sram_wren),
    .sram_q    (sram_q),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- SRAM model ----------------
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [AW-1:0] q_addr;

  function automatic logic [DW-1:0] init_word(int i);
    return (DW'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
    end else if (sram_wren) begin
      for (int b = 0; b < BY; b++)
        if (sram_b_en[b]) mem[sram_addr][8*b +: 8] <= sram_data[8*b +: 8];
    end
    q_addr <= sram_addr;
  end
  assign sram_q = mem[q_addr];

  int            wren_cnt = 0;
  logic [BY-1:0] last_b_en;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;
  always @(negedge clk) begin
    if (sram_wren) begin
      wren_cnt  <= wren_cnt + 1;
      last_b_en <= sram_b_en;
      last_addr <= sram_addr;
      last_data <= sram_data;
    end
  end

  // ---------------- scoreboard ----------------
  logic [XW-1:0] exp_q[$];
  vec_t          vecs[$];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic w, input logic [2:0] sz, input logic [31:0] a,
                              input logic [DW-1:0] d, input int ew, input logic er);
    vecs.push_back('{w, sz, a, d, ew, er});
  endfunction

  function automatic logic [BY-1:0] lanes_of(input logic [2:0] sz, input logic [1:0] off);
    case (sz)
      3'd0:    return 4'b0001 << off;
      3'd1:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_bad(input vec_t v);
    return (v.size > 3'd2) || (v.size == 3'd1 && v.addr[0]) ||
           (v.size == 3'd2 && v.addr[1:0] != 2'b00);
  endfunction

  function automatic void push_expect(input vec_t v);
    logic [DW-1:0] rd;
    logic [BY-1:0] ln;
    int            w;
    rd = '0;
    w  = int'(v.addr[AW+1:2]);
    if (!is_bad(v)) begin
      if (v.write) begin
        ln = lanes_of(v.size, v.addr[1:0]);
        for (int b = 0; b < BY; b++)
          if (ln[b]) ref_mem[w][8*b +: 8] = v.wdata[8*b +: 8];
      end else begin
        rd = ref_mem[w];
      end
    end
    exp_q.push_back({v.exp_resp, v.exp_resp, 2'(v.exp_waits), rd});
  endfunction

  // ---------------- driver ----------------
  task automatic drive_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'd0;
    bus.HADDR  = '0;
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge with the bus idle.
  task automatic run_vecs();
    int            nxt = 0;
    int            cur = -1;
    int            cyc = 0;
    int            waits = 0;
    int            budget;
    logic          resp_first = 1'b0;
    logic [XW-1:0] exp, act;
    budget = 8 * vecs.size() + 16;
    while ((nxt < vecs.size() || cur >= 0) && cyc < budget) begin
      if (nxt < vecs.size()) begin
        bus.HSEL   = 1'b1;
        bus.HTRANS = (nxt == 0) ? 2'b10 : 2'b11;
        bus.HWRITE = vecs[nxt].write;
        bus.HSIZE  = vecs[nxt].size;
        bus.HADDR  = vecs[nxt].addr;
      end else begin
        drive_idle();
      end
      bus.HWDATA = (cur >= 0) ? vecs[cur].wdata : '0;
      @(negedge clk);
      if (cur >= 0 && waits == 0) resp_first = bus.HRESP;
      if (bus.HREADYOUT) begin
        if (cur >= 0) begin
          exp = exp_q.pop_front();
          act = {resp_first, bus.HRESP, 2'(waits), bus.HRDATA};
          check($sformatf("xfer%0d_addr%0h{resp1,resp,waits,rdata}", cur, vecs[cur].addr),
                64'(act), 64'(exp));
        end
        if (nxt < vecs.size()) begin
          push_expect(vecs[nxt]);
          cur = nxt;
          nxt++;
        end else begin
          cur = -1;
        end
        waits = 0;
      end else if (cur >= 0) begin
        waits++;
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    if (nxt < vecs.size() || cur >= 0) begin
      n_vec++;
      n_err++;
      $display("FAIL run_vecs_timeout: got %0d cycles, expected completion of %0d transfers", cyc, vecs.size());
      exp_q.delete();
      drive_idle();
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int            cnt0;
    int            bad_words;
    logic          w, prev_wr;
    logic [2:0]    sz;
    logic [31:0]   a;

    drive_idle();
    bus.HWDATA = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    mem_init = 1'b0;
    #1;
    check("rst_hreadyout", 64'(bus.HREADYOUT), 64'd1);
    check("rst_hresp",     64'(bus.HRESP),     64'd0);
    check("rst_hrdata",    64'(bus.HRDATA),    64'd0);
    check("rst_wren",      64'(sram_wren),     64'd0);
    check("rst_b_en",      64'(sram_b_en),     64'd0);
    check("rst_addr",      64'(sram_addr),     64'd0);
    check("rst_data",      64'(sram_data),     64'd0);
    check("rst_state",     64'(dbg_state),     64'd0);
    @(posedge clk);
    #1;

    // Idle read of 0x40: zero wait, then the address stays put while idle.
    vecs.delete();
    add(1'b0, 3'd2, 32'h40, '0, 0, 1'b0);
    run_vecs();
    check("idle_read_addr_hold", 64'(sram_addr), 64'd16);

    // Byte write 0xAB at 0x21.
    cnt0 = wren_cnt;
    vecs.delete();
    add(1'b1, 3'd0, 32'h21, 32'h0000_AB00, 0, 1'b0);
    run_vecs();
    check("byte_wr_pulses", 64'(wren_cnt - cnt0), 64'd1);
    check("byte_wr_b_en",   64'(last_b_en),       64'b0010);
    check("byte_wr_addr",   64'(last_addr),       64'd8);
    check("byte_wr_mem",    64'(mem[8][15:8]),    64'hAB);

    // Unselected or non-transfer cycles must not start anything.
    cnt0 = wren_cnt;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HSIZE = 3'd2; bus.HADDR = 32'h80;
    @(posedge clk); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b01;
    @(posedge clk); #1;
    check("no_accept_state", 64'(dbg_state), 64'd0);
    drive_idle();
    @(posedge clk); #1;
    check("no_accept_wren", 64'(wren_cnt - cnt0), 64'd0);

    // Table of pipelined transfers: {write, size, addr, wdata, expected waits, expected resp}.
    vecs.delete();
    add(1'b1, 3'd2, 32'h10,  32'h1234_5678, 0,        1'b0);
    add(1'b0, 3'd2, 32'h10,  '0,            1,        1'b0);
    add(1'b1, 3'd0, 32'h21,  32'h0000_CD00, 0,        1'b0);
    add(1'b1, 3'd1, 32'h22,  32'hBEEF_0000, 0,        1'b0);
    add(1'b1, 3'd2, 32'h24,  32'hCAFE_F00D, 0,        1'b0);
    add(1'b0, 3'd2, 32'h20,  '0,            1,        1'b0);
    add(1'b0, 3'd2, 32'h40,  '0,            0,        1'b0);
    add(1'b0, 3'd0, 32'h41,  '0,            0,        1'b0);
    add(1'b1, 3'd2, 32'h02,  32'hFFFF_FFFF, ERR_WAIT, ERR_RESP);
    add(1'b0, 3'd2, 32'h10,  '0,            0,        1'b0);
    add(1'b0, 3'd1, 32'h13,  '0,            ERR_WAIT, ERR_RESP);
    add(1'b1, 3'd3, 32'h30,  32'h7777_7777, ERR_WAIT, ERR_RESP);
    add(1'b1, 3'd1, 32'h32,  32'h5A5A_0000, 0,        1'b0);
    add(1'b0, 3'd2, 32'h30,  '0,            1,        1'b0);
    add(1'b1, 3'd2, 32'hFFC, 32'hDEAD_BEEF, 0,        1'b0);
    add(1'b0, 3'd2, 32'hFFC, '0,            1,        1'b0);
    add(1'b0, 3'd2, 32'h0,   '0,            0,        1'b0);
    add(1'b1, 3'd2, 32'h60,  32'h0102_0304, 0,        1'b0);
    add(1'b0, 3'd2, 32'h61,  '0,            ERR_WAIT, ERR_RESP);
    add(1'b0, 3'd2, 32'h60,  '0,            0,        1'b0);
    run_vecs();

    // Random legal traffic over a small window so reads often follow writes to the same word.
    vecs.delete();
    prev_wr = 1'b0;
    for (int k = 0; k < 24; k++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 15)) * 4;
      if (sz == 3'd0) a = a + 32'($urandom_range(0, 3));
      if (sz == 3'd1) a = a + 32'($urandom_range(0, 1)) * 2;
      add(w, sz, a, DW'($urandom), (!w && prev_wr) ? 1 : 0, 1'b0);
      prev_wr = w;
    end
    run_vecs();

    // Reset during the data phase of a write must drop it.
    cnt0 = wren_cnt;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HSIZE = 3'd2; bus.HADDR = 32'h50;
    @(posedge clk); #1;
    drive_idle();
    bus.HWDATA = 32'h1111_2222;
    check("rstwr_in_wr", 64'(dbg_state), 64'd1);
    rst = 1'b1;
    #1;
    check("rstwr_wren",      64'(sram_wren),     64'd0);
    check("rstwr_state",     64'(dbg_state),     64'd0);
    check("rstwr_hreadyout", 64'(bus.HREADYOUT), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rstwr_no_pulse", 64'(wren_cnt - cnt0), 64'd0);
    check("rstwr_mem",      64'(mem[20]),         64'(ref_mem[20]));

    bad_words = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== ref_mem[i]) bad_words++;
    check("final_mem_words_differing", 64'(bad_words), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_sram_if.md
AHB_SRAM_IF -- requirements
Module: ahb_sram_if

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 10: SRAM word-address width.
REQ-002 Parameter DATA_WIDTH, default 32: bus and SRAM data width.
REQ-003 Parameter BYTES, default 4: byte lanes per word.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous reset, active high.
REQ-007 HSEL  in  1  slave select.
REQ-008 HADDR  in  32  byte address; word address is HADDR[ADDRESS_WIDTH+1:2].
REQ-009 HTRANS  in  2  transfer type; NONSEQ=2'b10, SEQ=2'b11.
REQ-010 HWRITE  in  1  1=write, 0=read.
REQ-011 HSIZE  in  3  0=byte, 1=half, 2=word.
REQ-012 HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
REQ-013 HREADY  in  1  bus-wide ready.
REQ-014 HRDATA  out  DATA_WIDTH  read data.
REQ-015 HREADYOUT  out  1  slave ready.
REQ-016 HRESP  out  1  0=OKAY, 1=ERROR.
REQ-017 sram_addr  out  ADDRESS_WIDTH  SRAM address.
REQ-018 sram_data  out  DATA_WIDTH  SRAM write data.
REQ-019 sram_b_en  out  BYTES  SRAM byte-lane enables.
REQ-020 sram_wren  out  1  SRAM write strobe.
REQ-021 sram_q  in  DATA_WIDTH  SRAM read data; address registered, data one cycle later.

Function
REQ-022 Accept an address phase only when HSEL & HREADY & HTRANS[1]=1; all other cycles are IDLE with no SRAM access.
REQ-023 FSM states: IDLE, WR, RD, RD_STALL, ERR1, ERR2; state meaning = type of current data phase.
REQ-024 An accepted write SHALL latch the word address, byte lanes and HWRITE, then enter WR.
REQ-025 In WR, assert sram_wren=1, sram_addr=latched address, sram_data=HWDATA, sram_b_en=latched lanes, and HREADYOUT=1 (zero wait).
REQ-026 Lane decode: byte -> one-hot bit HADDR[1:0]; half -> 4'b0011 (HADDR[1]=0) or 4'b1100; word -> 4'b1111.
REQ-027 An accepted read outside WR SHALL drive sram_addr=HADDR word address combinationally in the address cycle, then enter RD.
REQ-028 In RD, HRDATA=sram_q and HREADYOUT=1 (zero wait).
REQ-029 A read accepted while in WR (SRAM port busy) SHALL latch its address and enter RD_STALL.
REQ-030 RD_STALL: sram_addr=latched read address, HREADYOUT=0 for exactly one cycle, then RD; read-after-write costs exactly one wait state and returns the newly written data.
REQ-031 Outside WR and RD_STALL with no accepted read, sram_addr holds its last value and sram_wren=0.
REQ-032 Back-to-back writes SHALL complete with no wait states.
REQ-033 HREADYOUT=0 SHALL block acceptance of any new address phase in that cycle.

Reset
REQ-034 On rst, the FSM SHALL go to IDLE and outputs SHALL reset to: HREADYOUT=1, HRESP=0, HRDATA=0, sram_wren=0, sram_b_en=0, sram_addr=0, sram_data=0.
REQ-035 rst asserted during WR or RD_STALL SHALL drop the pending transfer with no SRAM write.

Configuration
REQ-036 Macro AHB_SRAM_IF_ERR_EN.
REQ-037 With AHB_SRAM_IF_ERR_EN defined: HSIZE>2, a misaligned half (HADDR[0]=1) or a misaligned word (HADDR[1:0]!=0) SHALL give a two-cycle ERROR: ERR1 (HRESP=1, HREADYOUT=0), then ERR2 (HRESP=1, HREADYOUT=1), with no SRAM write.
REQ-038 Without the macro: ERR1/ERR2 are absent and such transfers SHALL complete OKAY with zero wait, sram_wren=0 and HRDATA=0.

Verification
REQ-039 Word write 0x12345678 to 0x10, then read 0x10 -> write has zero wait, read has one RD_STALL cycle, then HRDATA=0x12345678.
REQ-040 Byte write 0xAB at 0x21 -> sram_b_en=4'b0010, sram_addr=8, sram_wren high for exactly one cycle.
REQ-041 Idle read of 0x40 -> HREADYOUT stays 1 and HRDATA=sram[16] in the data phase.
REQ-042 rst pulsed during WR -> sram_wren=0, FSM in IDLE, HREADYOUT=1, memory unchanged.
REQ-043 With macro: word write to 0x02 -> HRESP=1 for 2 cycles, HREADYOUT 0 then 1, no write; without macro: OKAY and no write.
